chdr_header_strip: RTL and testbench

Receive-side counterpart of the CHDR mux/framer path. It consumes a 64-bit CHDR packet stream, for example from a crossbar port, and strips the header word and the optional timestamp word. It presents the payload with the 128-bit header/time sideband on tuser, in the same format the framer accepts. The payload length is trimmed to the header's byte count, and malformed packets are flagged.

---
 rtl/chdr_header_strip.sv | 89 ++++++++
 tb/tb_chdr_header_strip.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chdr_header_strip.sv
// chdr_header_strip: strips CHDR header/timestamp words and forwards the payload with {header,time} on o_tuser
// Ports: clk, reset (sync, active-low), clear (sync, active-high)
//        i_tdata/i_tlast/i_tvalid/i_tready : 64-bit CHDR input stream
//        o_tdata/o_tuser/o_tlast/o_tvalid/o_tready : payload output, o_tuser = {header, timestamp}
//        o_err : one-cycle pulse per malformed packet
module chdr_header_strip (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [63:0]  i_tdata,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  output logic [63:0]  o_tdata,
  output logic [127:0] o_tuser,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready,
  output logic         o_err
);
  localparam logic [1:0] ST_HEADER = 2'd0, ST_TIME = 2'd1, ST_BODY = 2'd2, ST_DRAIN = 2'd3;
  logic [1:0]  state;
  logic [12:0] count, pw, pw_in;
  logic [63:0] hdr, tim;
  logic [15:0] len_in;
  logic        ht_in, bad_in, empty_in, at_end, body, hs, err;
  // Payload word count of a header; only meaningful once the length has been checked as well-formed.
  function automatic logic [12:0] words(input logic [63:0] h);
    logic [15:0] pb;
    pb = h[47:32] - 16'd8 - (h[61] ? 16'd8 : 16'd0);
    return 13'((pb + 16'd7) >> 3);
  endfunction
  assign len_in   = i_tdata[47:32];
  assign ht_in    = i_tdata[61];
  assign pw_in    = words(i_tdata);
  assign pw       = words(hdr);
  assign bad_in   = (len_in < 16'd8) || (ht_in && len_in < 16'd16);
  // A bare header with tlast and length 8 is a legal empty packet, not an error.
  assign empty_in = (len_in == 16'd8) && !ht_in && i_tlast;
  assign at_end   = count == pw;
  assign body     = state == ST_BODY;
  assign i_tready = body ? o_tready : 1'b1;
  assign hs       = i_tvalid && i_tready;
  assign o_tvalid = body && i_tvalid;
  assign o_tdata  = i_tdata;
  assign o_tlast  = body && (at_end || i_tlast);
  assign o_tuser  = {hdr, tim};
  assign o_err    = err;
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state <= ST_HEADER;
      count <= '0;
      hdr   <= '0;
      tim   <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (hs) begin
        case (state)
          ST_HEADER: begin
            hdr   <= i_tdata;
            tim   <= '0;
            count <= 13'd1;
            if (empty_in) state <= ST_HEADER;
            else if (bad_in || i_tlast) begin
              err   <= 1'b1;
              state <= i_tlast ? ST_HEADER : ST_DRAIN;
            end else state <= ht_in ? ST_TIME : (pw_in == '0 ? ST_DRAIN : ST_BODY);
          end
          ST_TIME: begin
            tim <= i_tdata;
            if (i_tlast) begin
              err   <= pw != '0;
              state <= ST_HEADER;
            end else state <= pw == '0 ? ST_DRAIN : ST_BODY;
          end
          ST_BODY: begin
            if (i_tlast) begin
              err   <= !at_end;
              state <= ST_HEADER;
            end else if (at_end) state <= ST_DRAIN;
            else count <= count + 13'd1;
          end
          default: state <= i_tlast ? ST_HEADER : ST_DRAIN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chdr_header_strip.sv
// tb_chdr_header_strip: directed and randomized-traffic bench for chdr_header_strip
module tb_chdr_header_strip;
  typedef struct packed {
    logic [63:0]  d;
    logic         l;
    logic [127:0] u;
  } beat_t;
  logic         clk = 1'b0;
  logic         reset, clear;
  logic [63:0]  i_tdata;
  logic         i_tlast, i_tvalid, i_tready;
  logic [63:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast, o_tvalid, o_tready, o_err;
  int           errors = 0, checks = 0, nerr = 0;
  bit           rnd = 0, gaps = 0;
  beat_t        got[$];
  chdr_header_strip dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .o_err(o_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (o_tvalid && o_tready) got.push_back({o_tdata, o_tlast, o_tuser});
    if (o_err) nerr++;
  end
  function automatic logic [63:0] mkh(input logic ht, input logic [15:0] len);
    return {2'b00, ht, 1'b0, 12'h123, len, 32'h0000_0A0B};
  endfunction
  function automatic beat_t mkb(input logic [63:0] d, input logic l, input logic [127:0] u);
    return {d, l, u};
  endfunction
  task automatic send(input logic [63:0] w, input logic l);
    int n = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      i_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    i_tdata = w; i_tlast = l; i_tvalid = 1'b1;
    forever begin
      if (rnd) o_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i_tready) break;
      n++;
      if (n > 200) break;
      @(posedge clk); #1;
    end
    checks++;
    if (n > 200) begin
      errors++;
      $display("FAIL send timeout: word %h not accepted after %0d cycles, required accept", w, n);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask
  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    checks++;
    if ({o_tvalid, o_tlast, o_err, i_tready} !== 4'b0001 || o_tuser !== '0) begin
      errors++;
      $display("FAIL reset: got vld/last/err/rdy=%b tuser=%h, required 0001 tuser=0", {o_tvalid, o_tlast, o_err, i_tready}, o_tuser);
    end
  endtask
  task automatic test_no_time();
    beat_t exp[$];
    logic [63:0] h = mkh(1'b0, 16'd32);
    got.delete(); nerr = 0;
    send(h, 0); send(64'hD0, 0); send(64'hD1, 0); send(64'hD2, 1);
    settle();
    exp = '{mkb(64'hD0, 0, {h, 64'h0}), mkb(64'hD1, 0, {h, 64'h0}), mkb(64'hD2, 1, {h, 64'h0})};
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL no_time beats: got %0d required %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL no_time beat%0d: got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL no_time err: got %0d required 0", nerr); end
  endtask
  task automatic test_time();
    beat_t exp[$];
    logic [63:0] h = mkh(1'b1, 16'd36), t = 64'hFEED_0000_1234_5678;
    got.delete(); nerr = 0;
    send(h, 0); send(t, 0); send(64'hA0, 0); send(64'hA1, 0); send(64'hA2, 1);
    settle();
    exp = '{mkb(64'hA0, 0, {h, t}), mkb(64'hA1, 0, {h, t}), mkb(64'hA2, 1, {h, t})};
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL time beats: got %0d required %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL time beat%0d: got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL time err: got %0d required 0", nerr); end
  endtask
  task automatic test_trim_drain();
    beat_t exp[$];
    logic [63:0] h = mkh(1'b0, 16'd24), h2 = mkh(1'b0, 16'd16);
    got.delete(); nerr = 0;
    send(h, 0); send(64'hB0, 0); send(64'hB1, 0); send(64'hB2, 0); send(64'hB3, 1);
    send(h2, 0); send(64'hC0, 1);
    settle();
    exp = '{mkb(64'hB0, 0, {h, 64'h0}), mkb(64'hB1, 1, {h, 64'h0}), mkb(64'hC0, 1, {h2, 64'h0})};
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL trim beats: got %0d required %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL trim beat%0d: got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL trim err: got %0d required 0", nerr); end
  endtask
  task automatic test_early_tlast();
    beat_t exp[$];
    logic [63:0] h = mkh(1'b0, 16'd40);
    got.delete(); nerr = 0;
    send(h, 0); send(64'hE0, 0); send(64'hE1, 1);
    settle();
    exp = '{mkb(64'hE0, 0, {h, 64'h0}), mkb(64'hE1, 1, {h, 64'h0})};
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL early beats: got %0d required %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL early beat%0d: got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (nerr !== 1) begin errors++; $display("FAIL early err: got %0d required 1", nerr); end
  endtask
  task automatic test_malformed();
    got.delete(); nerr = 0;
    send(mkh(1'b1, 16'd12), 0); send(64'h1, 0); send(64'h2, 1);
    settle();
    checks++;
    if (got.size() != 0 || nerr !== 1) begin
      errors++;
      $display("FAIL malformed: got beats=%0d errs=%0d required beats=0 errs=1", got.size(), nerr);
    end
    got.delete(); nerr = 0;
    send(mkh(1'b0, 16'd8), 1);
    send(mkh(1'b1, 16'd16), 0); send(64'h77, 1);
    send(mkh(1'b0, 16'd40), 1);
    settle();
    checks++;
    if (got.size() != 0 || nerr !== 1) begin
      errors++;
      $display("FAIL empty/short: got beats=%0d errs=%0d required beats=0 errs=1", got.size(), nerr);
    end
  endtask
  task automatic test_random();
    beat_t exp[$];
    int experr = 0;
    got.delete(); nerr = 0; rnd = 1; gaps = 1;
    for (int p = 0; p < 1000; p++) begin
      logic ht = 1'($urandom_range(0, 1));
      int pw = $urandom_range(1, 4), nin = $urandom_range(1, 5), m;
      logic [15:0] len = 16'(8 * pw - $urandom_range(0, 7) + 8 + (ht ? 8 : 0));
      logic [63:0] h = mkh(ht, len), t = {$urandom, $urandom};
      logic [127:0] u = {h, ht ? t : 64'h0};
      m = nin < pw ? nin : pw;
      if (nin < pw) experr++;
      send(h, 0);
      if (ht) send(t, 0);
      for (int i = 0; i < nin; i++) begin
        logic [63:0] d = {$urandom, $urandom};
        send(d, i == nin - 1);
        if (i < m) exp.push_back(mkb(d, i == m - 1, u));
      end
    end
    rnd = 0; gaps = 0; o_tready = 1'b1;
    settle();
    checks++;
    if (got.size() != exp.size()) begin errors++; $display("FAIL random beats: got %0d required %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL random beat%0d: got %h required %h", i, got[i], exp[i]); end
    end
    checks++;
    if (nerr !== experr) begin errors++; $display("FAIL random err: got %0d required %0d", nerr, experr); end
  endtask
  task automatic test_mid_abort();
    logic [63:0] h = mkh(1'b0, 16'd16);
    for (int k = 0; k < 2; k++) begin
      send(mkh(1'b0, 16'd32), 0); send(64'h11, 0);
      i_tdata = 64'h22; i_tvalid = 1'b1; o_tready = 1'b0;
      if (k == 0) reset = 1'b0; else clear = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_tvalid !== 1'b0 || i_tready !== 1'b1 || o_tuser !== '0) begin
        errors++;
        $display("FAIL abort%0d: got vld=%b rdy=%b tuser=%h required vld=0 rdy=1 tuser=0", k, o_tvalid, i_tready, o_tuser);
      end
      reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    end
    got.delete(); nerr = 0;
    send(h, 0); send(64'h33, 1);
    settle();
    checks++;
    if (got.size() != 1 || got[0] !== mkb(64'h33, 1, {h, 64'h0}) || nerr !== 0) begin
      errors++;
      $display("FAIL abort recovery: got beats=%0d errs=%0d required one beat 33 with tlast, errs=0", got.size(), nerr);
    end
  endtask
  initial begin
    reset = 1'b0; clear = 1'b0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_no_time();
    test_time();
    test_trim_drain();
    test_early_tlast();
    test_malformed();
    test_random();
    test_mid_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
